instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//  Instruction-memory responder on the DataPath fetch port (pcQ in, instruction out).
//  At startup it accepts a program as a big-endian byte stream (valid/ready) and packs it into words.
//  It then releases the core and answers fetches combinationally.
//  The bench uses it to preload programs without editing RTL.
// PARAMETERS
//  DEPTH   64  number of 32-bit instruction words held
//  ADDR_W  6   word-index width, log2(DEPTH)
// PORTS
//  clock        in   1         system clock, rising edge
//  resetN       in   1         asynchronous, active-low reset
//  loadValid    in   1         loadByte is valid this cycle
//  loadByte     in   8         program byte, most-significant byte of each word first
//  loadReady    out  1         block can accept a byte this cycle
//  loadDone     in   1         single-cycle pulse marking end of program
//  pcAddr       in   32        fetch byte address (DataPath pcQ)
//  instruction  out  32        fetched word (combinational)
//  running      out  1         program loaded; core may advance PC
//  loadError    out  1         sticky; overflow or partial last word
//  misaligned   out  1         pcAddr[1:0] != 0 while running (combinational)
//  wordCount    out  ADDR_W+1  number of complete words stored
// BEHAVIOUR
//  Reset (asynchronous, resetN low):
//   - state=LOAD, byteIdx=0, wordCount=0, shift register=0.
//   - loadError=0 and running=0.
//   - Memory array is not cleared.
//  FSM states: LOAD, RUN, ERROR.
//   - LOAD: loadReady=1. A byte transfers on a clock edge when loadValid & loadReady.
//     - Bytes shift into a 32-bit register: word = {word[23:0], loadByte}.
//     - byteIdx counts 0..3. When the 4th byte transfers, the word is written to mem[wordCount]
//       on that same edge, wordCount increments, and byteIdx returns to 0.
//   - LOAD -> RUN on loadDone when byteIdx==0 after any same-cycle transfer.
//     - A 4th byte and loadDone arriving together: the word is committed, then the block enters RUN.
//   - LOAD -> ERROR when either of these happens:
//     - loadDone arrives with byteIdx != 0 after the same-cycle transfer (partial word);
//     - loadValid is high while wordCount==DEPTH (overflow). The byte is dropped and memory is not written.
//   - RUN: loadReady=0, running=1. loadValid and loadDone are ignored.
//   - ERROR: loadReady=0, running=0, loadError=1. Only reset leaves this state.
//  Fetch (combinational in every state):
//   - idx = pcAddr[ADDR_W+1:2].
//   - instruction = mem[idx] when running, pcAddr[1:0]==0, idx < wordCount and pcAddr[31:ADDR_W+2]==0.
//   - Otherwise instruction = 32'h0000_0000 (nop).
//   - misaligned = running & (pcAddr[1:0] != 0).
//  Latency: 4 accepted bytes -> word readable once running. Fetch has zero cycles of latency.
//  Reset mid-load returns to LOAD with wordCount=0. Stale memory is never visible because idx < wordCount is required.
//  wordCount saturates at DEPTH and never wraps.
//  loadDone held high for several cycles is harmless: the block is already in RUN or ERROR.
// TESTING
//  1. Stream bytes 20,08,00,05, then 20,09,00,07, then pulse loadDone.
//     -> wordCount=2, running=1; pcAddr=0 -> 20080005, pcAddr=4 -> 20090007, pcAddr=8 -> 0.
//  2. Send 3 bytes, then loadDone -> loadError=1, running=0, loadReady=0. Pulse resetN -> LOAD with wordCount=0.
//  3. Send DEPTH*4 bytes, then 1 more -> loadError=1, wordCount=64, mem[63] intact.
//  4. 4th byte and loadDone in the same cycle -> word committed, running=1 on the next cycle.
//  5. Running with pcAddr=0x0000_0002 -> misaligned=1, instruction=0.
//     pcAddr=0x0000_1000 -> instruction=0, misaligned=0.
//  6. Assert resetN low after 6 bytes, then reload 4 bytes DEADBEEF and pulse loadDone.
//     -> wordCount=1, pcAddr=0 -> DEADBEEF, pcAddr=4 -> 0.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Bundle of the program-load stream, the fetch port and the status
// outputs of the instruction-memory loader.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              loadValid;
  logic [7:0]        loadByte;
  logic              loadReady;
  logic              loadDone;
  logic [31:0]       pcAddr;
  logic [31:0]       instruction;
  logic              running;
  logic              loadError;
  logic              misaligned;
  logic [ADDR_W:0]   wordCount;

  // Side that streams the program in and issues fetches (bench / core)
  modport master (
    output loadValid, loadByte, loadDone, pcAddr,
    input  loadReady, instruction, running, loadError, misaligned, wordCount
  );

  // Side that holds the program memory (the loader)
  modport slave (
    input  loadValid, loadByte, loadDone, pcAddr,
    output loadReady, instruction, running, loadError, misaligned, wordCount
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction-memory responder: packs a big-endian byte stream into 32-bit
// words at startup, then releases the core and serves fetches with zero
// latency. Fetch must be combinational, so the array is read asynchronously.
module instr_mem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              resetN,
  instr_mem_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] L_FULL = (ADDR_W + 1)'(DEPTH);

  state_t            r_state;
  logic [1:0]        r_byte_idx;
  logic [ADDR_W:0]   r_word_count;
  logic [31:0]       r_shift;
  logic              r_load_ready;
  logic              r_running;
  logic              r_load_error;
  logic [31:0]       r_mem [DEPTH];

  logic              w_in_load;
  logic              w_full;
  logic              w_overflow;
  logic              w_xfer;
  logic              w_word_done;
  logic [1:0]        w_byte_idx_after;
  logic [31:0]       w_shift_next;
  logic [ADDR_W-1:0] w_idx;
  logic              w_hit;

  // Load-side decode: a byte is accepted only while loading and not full;
  // a valid byte arriving when full is an overflow and is dropped.
  assign w_in_load        = (r_state == S_LOAD);
  assign w_full           = (r_word_count == L_FULL);
  assign w_overflow       = w_in_load && bus.loadValid && w_full;
  assign w_xfer           = w_in_load && bus.loadValid && !w_full;
  assign w_word_done      = w_xfer && (r_byte_idx == 2'd3);
  assign w_byte_idx_after = w_xfer ? 2'(r_byte_idx + 2'd1) : r_byte_idx;
  assign w_shift_next     = {r_shift[23:0], bus.loadByte};

  // Fetch decode: only complete, in-range, aligned words are visible, so
  // stale contents left over from an earlier load can never leak out.
  assign w_idx = bus.pcAddr[ADDR_W+1:2];
  assign w_hit = r_running
              && (bus.pcAddr[1:0] == 2'b00)
              && ({1'b0, w_idx} < r_word_count)
              && (bus.pcAddr[31:ADDR_W+2] == '0);

  assign bus.instruction = w_hit ? r_mem[w_idx] : 32'h0000_0000;
  assign bus.misaligned  = r_running && (bus.pcAddr[1:0] != 2'b00);
  assign bus.loadReady   = r_load_ready;
  assign bus.running     = r_running;
  assign bus.loadError   = r_load_error;
  assign bus.wordCount   = r_word_count;

  // Load FSM with registered status outputs; loadDone is judged against the
  // byte index after any transfer happening in the same cycle.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state      <= S_LOAD;
      r_byte_idx   <= 2'd0;
      r_word_count <= '0;
      r_shift      <= 32'h0;
      r_load_ready <= 1'b1;
      r_running    <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_xfer) begin
            r_shift    <= w_shift_next;
            r_byte_idx <= w_byte_idx_after;
          end
          if (w_word_done) begin
            r_word_count <= r_word_count + 1'b1;
          end
          if (w_overflow) begin
            r_state      <= S_ERROR;
            r_load_ready <= 1'b0;
            r_load_error <= 1'b1;
          end else if (bus.loadDone) begin
            r_load_ready <= 1'b0;
            if (w_byte_idx_after == 2'd0) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end else begin
              r_state      <= S_ERROR;
              r_load_error <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_state <= S_RUN;
        end
        S_ERROR: begin
          r_state <= S_ERROR;
        end
        default: begin
          r_state      <= S_ERROR;
          r_load_ready <= 1'b0;
          r_running    <= 1'b0;
          r_load_error <= 1'b1;
        end
      endcase
    end
  end

  // Program memory write; deliberately not reset so contents survive reset
  always_ff @(posedge clock) begin
    if (w_word_done) begin
      r_mem[r_word_count[ADDR_W-1:0]] <= w_shift_next;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader.
module tb_instr_mem_loader;

  logic clock;
  logic resetN;
  int   checks;
  int   errors;

  instr_mem_loader_if #(.ADDR_W(6)) bus ();

  instr_mem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    bus.loadValid = 1'b1;
    bus.loadByte  = b;
    @(posedge clock);
    #1;
    bus.loadValid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_done();
    @(negedge clock);
    bus.loadDone = 1'b1;
    @(posedge clock);
    #1;
    bus.loadDone = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    resetN = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    resetN = 1'b1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i));
    end
  endtask

  task automatic test_reset();
    apply_reset();
    bus.pcAddr = 32'h0;
    #1;
    checks += 5;
    if (bus.loadReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.loadReady); end
    if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", bus.running); end
    if (bus.loadError !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", bus.loadError); end
    if (bus.wordCount !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.wordCount); end
    if (bus.instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", bus.instruction); end
    bus.pcAddr = 32'h2;
    #1;
    checks++;
    if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b expected 0", bus.misaligned); end
    $display("test_reset done");
  endtask

  task automatic test_basic_load();
    apply_reset();
    send_word(32'h2008_0005);
    send_word(32'h2009_0007);
    checks++;
    if (bus.running !== 1'b0) begin errors++; $display("FAIL basic_prerun: got %b expected 0", bus.running); end
    pulse_done();
    checks += 3;
    if (bus.wordCount !== 7'd2) begin errors++; $display("FAIL basic_count: got %0d expected 2", bus.wordCount); end
    if (bus.running !== 1'b1) begin errors++; $display("FAIL basic_running: got %b expected 1", bus.running); end
    if (bus.loadReady !== 1'b0) begin errors++; $display("FAIL basic_ready: got %b expected 0", bus.loadReady); end
    bus.pcAddr = 32'h0; #1;
    checks++;
    if (bus.instruction !== 32'h2008_0005) begin errors++; $display("FAIL basic_pc0: got %h expected 20080005", bus.instruction); end
    bus.pcAddr = 32'h4; #1;
    checks++;
    if (bus.instruction !== 32'h2009_0007) begin errors++; $display("FAIL basic_pc4: got %h expected 20090007", bus.instruction); end
    bus.pcAddr = 32'h8; #1;
    checks++;
    if (bus.instruction !== 32'h0) begin errors++; $display("FAIL basic_pc8: got %h expected 00000000", bus.instruction); end
    // loads and loadDone are ignored while running
    send_word(32'h1111_2222);
    pulse_done();
    checks += 2;
    if (bus.wordCount !== 7'd2) begin errors++; $display("FAIL run_ignore_count: got %0d expected 2", bus.wordCount); end
    if (bus.running !== 1'b1 || bus.loadError !== 1'b0) begin errors++; $display("FAIL run_ignore_state: got running=%b err=%b expected 1/0", bus.running, bus.loadError); end
    $display("test_basic_load done");
  endtask

  task automatic test_partial_word();
    apply_reset();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    pulse_done();
    checks += 3;
    if (bus.loadError !== 1'b1) begin errors++; $display("FAIL partial_error: got %b expected 1", bus.loadError); end
    if (bus.running !== 1'b0) begin errors++; $display("FAIL partial_running: got %b expected 0", bus.running); end
    if (bus.loadReady !== 1'b0) begin errors++; $display("FAIL partial_ready: got %b expected 0", bus.loadReady); end
    apply_reset();
    #1;
    checks += 3;
    if (bus.wordCount !== 7'd0) begin errors++; $display("FAIL partial_reset_count: got %0d expected 0", bus.wordCount); end
    if (bus.loadReady !== 1'b1) begin errors++; $display("FAIL partial_reset_ready: got %b expected 1", bus.loadReady); end
    if (bus.loadError !== 1'b0) begin errors++; $display("FAIL partial_reset_error: got %b expected 0", bus.loadError); end
    $display("test_partial_word done");
  endtask

  task automatic test_full_and_overflow();
    // full memory then loadDone: every slot readable, out-of-range gives nop
    apply_reset();
    load_ramp();
    pulse_done();
    checks++;
    if (bus.wordCount !== 7'd64 || bus.running !== 1'b1) begin errors++; $display("FAIL full_run: got count=%0d running=%b expected 64/1", bus.wordCount, bus.running); end
    bus.pcAddr = 32'h0000_00FC; #1;
    checks++;
    if (bus.instruction !== 32'hFCFD_FEFF) begin errors++; $display("FAIL full_pc252: got %h expected fcfdfeff", bus.instruction); end
    bus.pcAddr = 32'h0000_0028; #1;
    checks++;
    if (bus.instruction !== 32'h2829_2A2B) begin errors++; $display("FAIL full_pc40: got %h expected 28292a2b", bus.instruction); end
    bus.pcAddr = 32'h0000_0100; #1;
    checks++;
    if (bus.instruction !== 32'h0) begin errors++; $display("FAIL full_pc256: got %h expected 00000000", bus.instruction); end
    // full memory then one extra byte: overflow
    apply_reset();
    load_ramp();
    checks++;
    if (bus.wordCount !== 7'd64 || bus.loadError !== 1'b0) begin errors++; $display("FAIL ovf_pre: got count=%0d err=%b expected 64/0", bus.wordCount, bus.loadError); end
    send_byte(8'h99);
    checks += 4;
    if (bus.loadError !== 1'b1) begin errors++; $display("FAIL ovf_error: got %b expected 1", bus.loadError); end
    if (bus.wordCount !== 7'd64) begin errors++; $display("FAIL ovf_count: got %0d expected 64", bus.wordCount); end
    if (dut.r_mem[63] !== 32'hFCFD_FEFF) begin errors++; $display("FAIL ovf_mem63: got %h expected fcfdfeff", dut.r_mem[63]); end
    if (dut.r_mem[0] !== 32'h0001_0203) begin errors++; $display("FAIL ovf_mem0: got %h expected 00010203", dut.r_mem[0]); end
    bus.pcAddr = 32'h0; #1;
    checks++;
    if (bus.instruction !== 32'h0) begin errors++; $display("FAIL ovf_fetch: got %h expected 00000000", bus.instruction); end
    $display("test_full_and_overflow done");
  endtask

  task automatic test_same_cycle_done();
    apply_reset();
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA);
    @(negedge clock);
    bus.loadValid = 1'b1;
    bus.loadByte  = 8'hBE;
    bus.loadDone  = 1'b1;
    @(posedge clock);
    #1;
    bus.loadValid = 1'b0;
    bus.loadDone  = 1'b0;
    bus.pcAddr    = 32'h0;
    #1;
    checks += 4;
    if (bus.running !== 1'b1) begin errors++; $display("FAIL same_running: got %b expected 1", bus.running); end
    if (bus.loadError !== 1'b0) begin errors++; $display("FAIL same_error: got %b expected 0", bus.loadError); end
    if (bus.wordCount !== 7'd1) begin errors++; $display("FAIL same_count: got %0d expected 1", bus.wordCount); end
    if (bus.instruction !== 32'hCAFE_BABE) begin errors++; $display("FAIL same_pc0: got %h expected cafebabe", bus.instruction); end
    $display("test_same_cycle_done done");
  endtask

  task automatic test_fetch_bounds();
    // continues from the running state left by test_same_cycle_done
    bus.pcAddr = 32'h0000_0002; #1;
    checks += 2;
    if (bus.misaligned !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", bus.misaligned); end
    if (bus.instruction !== 32'h0) begin errors++; $display("FAIL mis_instr: got %h expected 00000000", bus.instruction); end
    bus.pcAddr = 32'h0000_1000; #1;
    checks += 2;
    if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL high_flag: got %b expected 0", bus.misaligned); end
    if (bus.instruction !== 32'h0) begin errors++; $display("FAIL high_instr: got %h expected 00000000", bus.instruction); end
    $display("test_fetch_bounds done");
  endtask

  task automatic test_reset_midload();
    apply_reset();
    send_word(32'h0102_0304);
    send_byte(8'h05); send_byte(8'h06);
    checks++;
    if (bus.wordCount !== 7'd1) begin errors++; $display("FAIL mid_pre_count: got %0d expected 1", bus.wordCount); end
    @(negedge clock);
    resetN = 1'b0;
    #1;
    checks++;
    if (bus.wordCount !== 7'd0) begin errors++; $display("FAIL mid_async_count: got %0d expected 0", bus.wordCount); end
    @(negedge clock);
    resetN = 1'b1;
    send_word(32'hDEAD_BEEF);
    // loadDone held for several cycles must be harmless
    @(negedge clock);
    bus.loadDone = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    bus.loadDone = 1'b0;
    checks += 2;
    if (bus.wordCount !== 7'd1) begin errors++; $display("FAIL mid_count: got %0d expected 1", bus.wordCount); end
    if (bus.running !== 1'b1 || bus.loadError !== 1'b0) begin errors++; $display("FAIL mid_state: got running=%b err=%b expected 1/0", bus.running, bus.loadError); end
    bus.pcAddr = 32'h0; #1;
    checks++;
    if (bus.instruction !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mid_pc0: got %h expected deadbeef", bus.instruction); end
    bus.pcAddr = 32'h4; #1;
    checks++;
    if (bus.instruction !== 32'h0) begin errors++; $display("FAIL mid_pc4: got %h expected 00000000", bus.instruction); end
    $display("test_reset_midload done");
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    resetN        = 1'b1;
    bus.loadValid = 1'b0;
    bus.loadByte  = 8'h00;
    bus.loadDone  = 1'b0;
    bus.pcAddr    = 32'h0;
    test_reset();
    test_basic_load();
    test_partial_word();
    test_full_and_overflow();
    test_same_cycle_done();
    test_fetch_bounds();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
